// File: rtl/fm_radio_pkg.sv
// Shared FM-radio constants, the FSM state type and the Q-format dequantize helper.
// Defining STEREO_LMR_SAT_EN adds the saturate() helper.
package fm_radio_pkg;

  localparam int DATA_SIZE = 32;
  localparam int BITS      = 10;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MULT  = 2'd1,
    S_DEQ   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Truncates toward zero. Negative values get a bias of 2^bits-1 before the shift.
  function automatic logic signed [63:0] dequantize(input logic signed [63:0] p,
                                                    input int bits = BITS);
    logic signed [63:0] biased;
    biased = p;
    if (p[63]) biased = p + ((64'sd1 <<< bits) - 64'sd1);
    return biased >>> bits;
  endfunction

`ifdef STEREO_LMR_SAT_EN
  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DATA_SIZE - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DATA_SIZE - 1));

  function automatic logic [DATA_SIZE-1:0] saturate(input logic signed [63:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_SIZE-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_SIZE-1:0];
    return v[DATA_SIZE-1:0];
  endfunction
`endif

endpackage

// File: rtl/stereo_lmr_demod.sv
// Stereo L-R demodulator: multiplies the 38 kHz carrier by the L-R band and dequantizes the product.
// Optional macro STEREO_LMR_SAT_EN clamps the result instead of wrapping it.
//
// state   | meaning
// S_READ  | wait for both FIFOs to be non-empty, then pop the pair
// S_MULT  | full-width signed product of the latched pair
// S_DEQ   | dequantize, apply gain, register y_out
// S_WRITE | push y_out once the output FIFO has room
module stereo_lmr_demod #(
  parameter int DATA_SIZE  = fm_radio_pkg::DATA_SIZE,
  parameter int BITS       = fm_radio_pkg::BITS,
  parameter int GAIN_SHIFT = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] carrier_in,
  input  logic                 carrier_empty,
  output logic                 carrier_rd_en,
  input  logic [DATA_SIZE-1:0] lmr_in,
  input  logic                 lmr_empty,
  output logic                 lmr_rd_en,
  output logic [DATA_SIZE-1:0] y_out,
  output logic                 y_wr_en,
  input  logic                 y_out_full,
  output logic [31:0]          sample_count
);
  import fm_radio_pkg::*;

  state_t                 state_q, state_d;
  logic [DATA_SIZE-1:0]   a_q, a_d;
  logic [DATA_SIZE-1:0]   b_q, b_d;
  logic signed [63:0]     p_q, p_d;
  logic [DATA_SIZE-1:0]   y_q, y_d;
  logic [31:0]            count_q, count_d;
  logic signed [63:0]     deq;

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    p_d           = p_q;
    y_d           = y_q;
    count_d       = count_q;
    deq           = '0;
    carrier_rd_en = 1'b0;
    lmr_rd_en     = 1'b0;
    y_wr_en       = 1'b0;

    case (state_q)
      S_READ: begin
        // Pop only as a pair so the two streams stay sample-aligned.
        if (!reset && !carrier_empty && !lmr_empty) begin
          a_d           = carrier_in;
          b_d           = lmr_in;
          carrier_rd_en = 1'b1;
          lmr_rd_en     = 1'b1;
          state_d       = S_MULT;
        end
      end
      S_MULT: begin
        p_d     = 64'($signed(a_q)) * 64'($signed(b_q));
        state_d = S_DEQ;
      end
      S_DEQ: begin
        deq = dequantize(p_q, BITS) <<< GAIN_SHIFT;
`ifdef STEREO_LMR_SAT_EN
        y_d = saturate(deq);
`else
        y_d = deq[DATA_SIZE-1:0];
`endif
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!reset && !y_out_full) begin
          y_wr_en = 1'b1;
          count_d = count_q + 32'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_READ;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      y_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      y_q     <= y_d;
      count_q <= count_d;
    end
  end

  assign y_out        = y_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_stereo_lmr_demod.sv
// Directed bench for stereo_lmr_demod with show-ahead FIFO models on both inputs.
// Expected outputs follow the STEREO_LMR_SAT_EN setting of the build.
module tb_stereo_lmr_demod;

  logic        clock;
  logic        reset;
  logic [31:0] carrier_in;
  logic        carrier_empty;
  logic        carrier_rd_en;
  logic [31:0] lmr_in;
  logic        lmr_empty;
  logic        lmr_rd_en;
  logic [31:0] y_out;
  logic        y_wr_en;
  logic        y_out_full;
  logic [31:0] sample_count;

  int vectors;
  int miscompares;

  logic [31:0] cq[$];
  logic [31:0] lq[$];
  int          pop_cycles[$];
  int          wr_cycles[$];
  logic [31:0] wr_vals[$];
  int          cpops;
  int          lpops;
  int          cyc;

  stereo_lmr_demod dut (
    .clock        (clock),
    .reset        (reset),
    .carrier_in   (carrier_in),
    .carrier_empty(carrier_empty),
    .carrier_rd_en(carrier_rd_en),
    .lmr_in       (lmr_in),
    .lmr_empty    (lmr_empty),
    .lmr_rd_en    (lmr_rd_en),
    .y_out        (y_out),
    .y_wr_en      (y_wr_en),
    .y_out_full   (y_out_full),
    .sample_count (sample_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive();
    carrier_empty = (cq.size() == 0);
    carrier_in    = carrier_empty ? 32'd0 : cq[0];
    lmr_empty     = (lq.size() == 0);
    lmr_in        = lmr_empty ? 32'd0 : lq[0];
  endtask

  // One clock: capture strobes before the edge, apply FIFO pops after it.
  task automatic cycle();
    logic        cp, lp, w;
    logic [31:0] yv, dummy;
    #1;
    cp = carrier_rd_en;
    lp = lmr_rd_en;
    w  = y_wr_en;
    yv = y_out;
    @(posedge clock);
    if (cp) begin
      if (cq.size() > 0) dummy = cq.pop_front();
      cpops++;
      pop_cycles.push_back(cyc);
    end
    if (lp) begin
      if (lq.size() > 0) dummy = lq.pop_front();
      lpops++;
    end
    if (w) begin
      wr_vals.push_back(yv);
      wr_cycles.push_back(cyc);
    end
    cyc++;
    @(negedge clock);
    drive();
    #1;
  endtask

  task automatic clear_logs();
    pop_cycles.delete();
    wr_cycles.delete();
    wr_vals.delete();
    cpops = 0;
    lpops = 0;
  endtask

  task automatic run_until_writes(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (wr_vals.size() < n && k < budget) begin
      cycle();
      k++;
    end
    ok = (wr_vals.size() >= n);
  endtask

  function automatic logic [31:0] wr_at(input int i);
    return (i < wr_vals.size()) ? wr_vals[i] : 32'hxxxxxxxx;
  endfunction

  task automatic test_reset();
    cq.push_back(32'd1024);
    lq.push_back(32'd500);
    reset = 1'b1;
    drive();
    repeat (3) cycle();
    vectors++;
    if (carrier_rd_en !== 1'b0 || lmr_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rd_en: got %b/%b, want 0/0", carrier_rd_en, lmr_rd_en);
    end
    vectors++;
    if (y_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wr_en: got %b, want 0", y_wr_en);
    end
    vectors++;
    if (y_out !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_y_out: got %h, want 0", y_out);
    end
    vectors++;
    if (sample_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d, want 0", sample_count);
    end
    vectors++;
    if (cpops != 0) begin
      miscompares++;
      $display("FAIL reset_pops: got %0d pops, want 0", cpops);
    end
    reset = 1'b0;
    drive();
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    clear_logs();
    run_until_writes(1, 20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_timeout: got %0d writes, want 1", wr_vals.size());
    end
    vectors++;
    if (wr_at(0) !== 32'd500) begin
      miscompares++;
      $display("FAIL basic_value: got %h, want %h", wr_at(0), 32'd500);
    end
    lat = (wr_cycles.size() > 0 && pop_cycles.size() > 0) ? wr_cycles[0] - pop_cycles[0] : -1;
    vectors++;
    if (lat != 3) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d, want 3", lat);
    end
    repeat (3) cycle();
    vectors++;
    if (wr_vals.size() != 1) begin
      miscompares++;
      $display("FAIL basic_single_write: got %0d writes, want 1", wr_vals.size());
    end
    vectors++;
    if (sample_count !== 32'd1) begin
      miscompares++;
      $display("FAIL basic_count: got %0d, want 1", sample_count);
    end
    vectors++;
    if (y_out !== 32'd500) begin
      miscompares++;
      $display("FAIL basic_hold: got %h, want %h", y_out, 32'd500);
    end
  endtask

  task automatic test_sign();
    bit          ok;
    logic [31:0] exp_v[3];
    exp_v[0] = -32'sd3;
    exp_v[1] = 32'd0;
    exp_v[2] = -32'sd3;
    clear_logs();
    cq.push_back(-32'sd1024); lq.push_back(32'd3);
    cq.push_back(32'd1);      lq.push_back(-32'sd1);
    cq.push_back(32'd3);      lq.push_back(-32'sd1024);
    drive();
    run_until_writes(3, 30, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL sign_timeout: got %0d writes, want 3", wr_vals.size());
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (wr_at(i) !== exp_v[i]) begin
        miscompares++;
        $display("FAIL sign_value[%0d]: got %h, want %h", i, wr_at(i), exp_v[i]);
      end
    end
    vectors++;
    if (wr_cycles.size() < 2 || wr_cycles[1] - wr_cycles[0] != 4) begin
      miscompares++;
      $display("FAIL sign_throughput: got spacing %0d, want 4",
               (wr_cycles.size() < 2) ? -1 : wr_cycles[1] - wr_cycles[0]);
    end
    vectors++;
    if (sample_count !== 32'd4) begin
      miscompares++;
      $display("FAIL sign_count: got %0d, want 4", sample_count);
    end
  endtask

  task automatic test_align();
    bit          ok;
    logic [31:0] exp_v;
    clear_logs();
    for (int i = 0; i < 5; i++) cq.push_back(32'(1024 * (i + 1)));
    drive();
    repeat (20) cycle();
    vectors++;
    if (cpops != 0) begin
      miscompares++;
      $display("FAIL align_carrier_pop: got %0d pops, want 0", cpops);
    end
    vectors++;
    if (lpops != 0) begin
      miscompares++;
      $display("FAIL align_lmr_pop: got %0d pops, want 0", lpops);
    end
    for (int i = 0; i < 5; i++) lq.push_back(32'(100 + i));
    drive();
    run_until_writes(5, 60, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL align_timeout: got %0d writes, want 5", wr_vals.size());
    end
    for (int i = 0; i < 5; i++) begin
      exp_v = 32'((i + 1) * (100 + i));
      vectors++;
      if (wr_at(i) !== exp_v) begin
        miscompares++;
        $display("FAIL align_value[%0d]: got %h, want %h", i, wr_at(i), exp_v);
      end
    end
    vectors++;
    if (cpops != 5 || lpops != 5) begin
      miscompares++;
      $display("FAIL align_pop_count: got %0d/%0d, want 5/5", cpops, lpops);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    clear_logs();
    cq.push_back(32'd2048); lq.push_back(32'd7);
    cq.push_back(32'd1024); lq.push_back(32'd9);
    drive();
    n = 0;
    while (pop_cycles.size() == 0 && n < 10) begin
      cycle();
      n++;
    end
    vectors++;
    if (pop_cycles.size() == 0) begin
      miscompares++;
      $display("FAIL bp_pop_timeout: got 0 pops, want 1");
    end
    cycle();
    y_out_full = 1'b1;
    cycle();
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (y_wr_en !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_wr_en[%0d]: got %b, want 0", i, y_wr_en);
      end
      vectors++;
      if (y_out !== 32'd14) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got %h, want %h", i, y_out, 32'd14);
      end
      cycle();
    end
    vectors++;
    if (cpops != 1 || lpops != 1) begin
      miscompares++;
      $display("FAIL bp_no_pop: got %0d/%0d pops, want 1/1", cpops, lpops);
    end
    y_out_full = 1'b0;
    #1;
    vectors++;
    if (y_wr_en !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_wr: got %b, want 1", y_wr_en);
    end
    run_until_writes(2, 20, ok);
    vectors++;
    if (!ok || wr_at(0) !== 32'd14 || wr_at(1) !== 32'd9) begin
      miscompares++;
      $display("FAIL bp_values: got %h,%h, want %h,%h", wr_at(0), wr_at(1), 32'd14, 32'd9);
    end
    vectors++;
    if (sample_count !== 32'd11) begin
      miscompares++;
      $display("FAIL bp_count: got %0d, want 11", sample_count);
    end
  endtask

  task automatic test_overflow();
    bit          ok;
    logic [31:0] exp_pos, exp_neg;
`ifdef STEREO_LMR_SAT_EN
    exp_pos = 32'h7FFFFFFF;
    exp_neg = 32'h80000000;
`else
    exp_pos = 32'hFFC00000;
    exp_neg = 32'h00200000;
`endif
    clear_logs();
    cq.push_back(32'h7FFFFFFF); lq.push_back(32'h7FFFFFFF);
    cq.push_back(32'h7FFFFFFF); lq.push_back(32'h80000000);
    drive();
    run_until_writes(2, 20, ok);
    vectors++;
    if (wr_at(0) !== exp_pos) begin
      miscompares++;
      $display("FAIL ovf_pos: got %h, want %h", wr_at(0), exp_pos);
    end
    vectors++;
    if (wr_at(1) !== exp_neg) begin
      miscompares++;
      $display("FAIL ovf_neg: got %h, want %h", wr_at(1), exp_neg);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    clear_logs();
    cq.push_back(32'd1024); lq.push_back(32'd77);
    drive();
    n = 0;
    while (pop_cycles.size() == 0 && n < 10) begin
      cycle();
      n++;
    end
    cycle();
    reset = 1'b1;
    cycle();
    vectors++;
    if (y_out !== 32'd0 || sample_count !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid_regs: got y=%h count=%0d, want 0/0", y_out, sample_count);
    end
    vectors++;
    if (y_wr_en !== 1'b0 || carrier_rd_en !== 1'b0 || lmr_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_strobes: got wr=%b rd=%b/%b, want 0", y_wr_en, carrier_rd_en, lmr_rd_en);
    end
    reset = 1'b0;
    drive();
    repeat (6) cycle();
    vectors++;
    if (wr_vals.size() != 0) begin
      miscompares++;
      $display("FAIL rst_mid_aborted: got %0d writes, want 0", wr_vals.size());
    end
    cq.push_back(32'd1024); lq.push_back(32'd33);
    drive();
    run_until_writes(1, 20, ok);
    vectors++;
    if (wr_at(0) !== 32'd33) begin
      miscompares++;
      $display("FAIL rst_mid_next: got %h, want %h", wr_at(0), 32'd33);
    end
    vectors++;
    if (sample_count !== 32'd1) begin
      miscompares++;
      $display("FAIL rst_mid_count: got %0d, want 1", sample_count);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    cpops       = 0;
    lpops       = 0;
    reset       = 1'b1;
    y_out_full  = 1'b0;
    drive();
    test_reset();
    test_basic();
    test_sign();
    test_align();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
